// File: rtl/glb_xbus_if.sv
// Multicast X-bus link between the global-buffer driver (master) and the
// PE-array multicaster (slave): tagged words under valid/ready flow control.
interface glb_xbus_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TW         = 3
);
  logic                  bus_valid;
  logic [TW-1:0]         bus_tag;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  bus_ready;

  modport master (
    output bus_valid,
    output bus_tag,
    output bus_data,
    input  bus_ready
  );

  modport slave (
    input  bus_valid,
    input  bus_tag,
    input  bus_data,
    output bus_ready
  );
endinterface

// File: rtl/glb_xbus_driver.sv
// Global-buffer X-bus driver: programs PE multicast tags, then streams a
// contiguous SRAM run onto the tagged bus through a 4-entry output FIFO.
module glb_xbus_driver #(
  parameter int  DATA_WIDTH = 16,
  parameter int  NUM_COL    = 4,
  parameter int  NUM_PE     = 4,
  parameter int  ADDR_WIDTH = 10,
  localparam int TW         = $clog2(NUM_COL) + 1,
  localparam int PW         = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  cfg_tag_en,
  input  logic [NUM_PE*TW-1:0]  cfg_tags,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic [TW-1:0]         cfg_bus_tag,
  output logic                  busy,
  output logic                  done,
  output logic                  tag_valid,
  output logic [PW-1:0]         tag_sel,
  output logic [TW-1:0]         tag_out,
  input  logic [NUM_PE-1:0]     tag_lock,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  glb_xbus_if.master            xbus
);

  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                state_q,   state_d;
  logic [NUM_PE*TW-1:0]  tags_q,    tags_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [ADDR_WIDTH:0]   rem_q,     rem_d;
  logic [TW-1:0]         bus_tag_q, bus_tag_d;
  logic [PW-1:0]         tag_idx_q, tag_idx_d;
  logic                  inflight_q, inflight_d;

  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            count_q,  count_d;

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  lock_hit;
  logic                  last_pe;
  logic [2:0]            room_used;
  logic                  drain_empty;

  assign push      = inflight_q;
  assign pop       = (count_q != 3'd0) && xbus.bus_ready;
  assign lock_hit  = tag_lock[tag_idx_q];
  assign last_pe   = (tag_idx_q == PW'(NUM_PE - 1));
  // Reads are only issued while the FIFO can absorb every word already in flight.
  assign room_used = count_q + {2'b00, inflight_q};
  // Looks through this cycle's pop so done lands one cycle after the last handshake.
  assign drain_empty = !inflight_q &&
                       ((count_q == 3'd0) || ((count_q == 3'd1) && pop));

  always_comb begin
    state_d   = state_q;
    tags_d    = tags_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    bus_tag_d = bus_tag_q;
    tag_idx_d = tag_idx_q;
    issue     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tags_d    = cfg_tags;
          addr_d    = cfg_base;
          rem_d     = cfg_len;
          bus_tag_d = cfg_bus_tag;
          tag_idx_d = '0;
          if (cfg_tag_en) begin
            state_d = ST_TAG;
          end else if (cfg_len != '0) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_TAG: begin
        if (lock_hit) begin
          if (last_pe) begin
            tag_idx_d = '0;
            state_d   = (rem_q == '0) ? ST_DONE : ST_STREAM;
          end else begin
            tag_idx_d = tag_idx_q + 1'b1;
          end
        end
      end

      ST_STREAM: begin
        if (room_used <= 3'd2) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (drain_empty) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inflight_d = issue;
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      tags_q     <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      bus_tag_q  <= '0;
      tag_idx_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      tags_q     <= tags_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      bus_tag_q  <= bus_tag_d;
      tag_idx_q  <= tag_idx_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign tag_valid = (state_q == ST_TAG);
  assign tag_sel   = tag_valid ? tag_idx_q : '0;
  assign tag_out   = tag_valid ? tags_q[TW*int'(tag_idx_q) +: TW] : '0;
  assign mem_rden  = issue;
  assign mem_addr  = addr_q;

  assign xbus.bus_valid = (count_q != 3'd0);
  assign xbus.bus_data  = fifo_q[rd_ptr_q];
  assign xbus.bus_tag   = bus_tag_q;

  fifo_no_overflow: assert property (
    @(posedge clk) disable iff (!rstn)
      !(push && !pop && (count_q == 3'(FIFO_DEPTH)))
  );

endmodule
